// File: rtl/cpu_core.sv
// cpu_core: single-cycle RV64I-subset core with NPU launch path.
// Optional feature macro: CPU_NPU_EN (custom-0 NPU launch/wait FSM).
module cpu_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);
  logic [XLEN-1:0] registers [0:31];

  // clear on reset, otherwise write rd (x0 is never written)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      registers[rd_addr] <= wd;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : registers[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : registers[rs2_addr];
endmodule

module cpu_core #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [63:0]     instr,
  input  logic [XLEN-1:0] read_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] write_data,
  output logic            mem_write_enable,
  output logic [XLEN-1:0] mem_addr,
  output logic            npu_start_matrix_mul,
  output logic            npu_start_conv,
  input  logic            npu_done
);
  logic [6:0] opcode, funct7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] rs1_val, rs2_val, wb_data;
  logic [XLEN-1:0] alu_a, alu_b, alu_out, pc_next, pc_d, pc4;
  logic [2:0] alu_f3;
  logic alu_alt, reg_we, stall, r_ok, i_ok;
  logic is_r, is_i, is_ld, is_sd, is_br, is_jal, is_lui, is_npu;
  logic [5:0] shamt;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};

  assign r_ok = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
  assign i_ok = (f3 == 3'b001) ? (instr[31:26] == 6'b000000) :
                (f3 == 3'b101) ? (instr[31:26] == 6'b000000 ||
                                  instr[31:26] == 6'b010000) : 1'b1;

  assign is_r   = opcode == 7'b0110011 && r_ok;
  assign is_i   = opcode == 7'b0010011 && i_ok;
  assign is_ld  = opcode == 7'b0000011 && f3 == 3'b011;
  assign is_sd  = opcode == 7'b0100011 && f3 == 3'b011;
  assign is_br  = opcode == 7'b1100011 && f3[2:1] == 2'b00;
  assign is_jal = opcode == 7'b1101111;
  assign is_lui = opcode == 7'b0110111;

  cpu_regfile #(.XLEN(XLEN)) regfile_unit (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .we       (reg_we && !stall),
    .wd       (wb_data),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val)
  );

  assign pc4 = pc + XLEN'(4);

  // decode: pick ALU operands/op, rd write and next pc
  always_comb begin
    alu_a   = rs1_val;
    alu_b   = rs2_val;
    alu_f3  = 3'b000;
    alu_alt = 1'b0;
    reg_we  = 1'b0;
    pc_next = pc4;
    unique case (1'b1)
      is_r: begin
        alu_f3  = f3;
        alu_alt = funct7[5];
        reg_we  = 1'b1;
      end
      is_i: begin
        alu_b   = imm_i;
        alu_f3  = f3;
        alu_alt = (f3 == 3'b101) && instr[30];
        reg_we  = 1'b1;
      end
      is_ld: begin
        alu_b  = imm_i;
        reg_we = 1'b1;
      end
      is_sd: alu_b = imm_s;
      is_br: begin
        alu_alt = 1'b1;
        if ((rs1_val == rs2_val) ^ f3[0]) pc_next = pc + imm_b;
      end
      is_jal: begin
        alu_a   = pc;
        alu_b   = XLEN'(4);
        reg_we  = 1'b1;
        pc_next = pc + imm_j;
      end
      is_lui: begin
        alu_a  = '0;
        alu_b  = imm_u;
        reg_we = 1'b1;
      end
      default: ;
    endcase
  end

  // integer ALU
  always_comb begin
    shamt = alu_b[5:0];
    case (alu_f3)
      3'b000: alu_out = alu_alt ? alu_a - alu_b : alu_a + alu_b;
      3'b001: alu_out = alu_a << shamt;
      3'b010: alu_out = {{(XLEN-1){1'b0}},
                         $signed(alu_a) < $signed(alu_b)};
      3'b011: alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      3'b100: alu_out = alu_a ^ alu_b;
      3'b101: alu_out = alu_alt ? XLEN'($signed(alu_a) >>> shamt)
                                : alu_a >> shamt;
      3'b110: alu_out = alu_a | alu_b;
      default: alu_out = alu_a & alu_b;
    endcase
  end

  assign wb_data          = is_ld ? read_data : alu_out;
  assign alu_result       = alu_out;
  assign mem_addr         = alu_out;
  assign write_data       = rs2_val;
  assign mem_write_enable = is_sd && !stall;

`ifdef CPU_NPU_EN
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  logic [0:0] state;
  logic launch;
  logic [31:0] unused_bits;

  assign unused_bits = instr[63:32];
  assign is_npu = opcode == 7'b0001011 && f3[2:1] == 2'b00;
  assign launch = is_npu && state == S_IDLE && !rst;
  assign npu_start_matrix_mul = launch && !f3[0];
  assign npu_start_conv       = launch && f3[0];
  assign stall = (state == S_WAIT) || is_npu;
  assign pc_d  = (state == S_WAIT) ? (npu_done ? pc4 : pc) :
                 (is_npu ? pc : pc_next);

  // launch moves to WAIT; npu_done releases the stall
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (state == S_IDLE) begin
      if (is_npu) state <= S_WAIT;
    end else if (npu_done) begin
      state <= S_IDLE;
    end
  end
`else
  logic [32:0] unused_bits;

  assign unused_bits = {instr[63:32], npu_done};
  assign is_npu = 1'b0;
  assign npu_start_matrix_mul = 1'b0;
  assign npu_start_conv       = 1'b0;
  assign stall = is_npu;
  assign pc_d  = pc_next;
`endif

  // program counter
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_d;
  end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed-vector bench for cpu_core.
// Covers ALU, loads/stores, branches, jumps, NOP and the NPU path.
module tb_cpu_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] instr, read_data, pc, alu_result, write_data, mem_addr;
  logic        mem_write_enable, npu_start_matrix_mul;
  logic        npu_start_conv, npu_done;
  logic [63:0] exp_pc;
  int n_checks = 0;
  int n_errs   = 0;

  cpu_core dut (
    .clk                  (clk),
    .rst                  (rst),
    .instr                (instr),
    .read_data            (read_data),
    .pc                   (pc),
    .alu_result           (alu_result),
    .write_data           (write_data),
    .mem_write_enable     (mem_write_enable),
    .mem_addr             (mem_addr),
    .npu_start_matrix_mul (npu_start_matrix_mul),
    .npu_start_conv       (npu_start_conv),
    .npu_done             (npu_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] b_type(input logic [12:0] im,
    input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f);
    return {32'h0, im[12], im[10:5], r2, r1, f, im[4:1], im[11],
            7'b1100011};
  endfunction

  function automatic logic [63:0] j_type(input logic [20:0] im,
    input logic [4:0] rdx);
    return {32'h0, im[20], im[10:1], im[11], im[19:12], rdx,
            7'b1101111};
  endfunction

  initial begin
    rst = 1'b1;
    instr = 64'h13;
    read_data = '0;
    npu_done = 1'b0;
    tick();
    tick();
    check("rst_pc", pc, 64'h0);
    check("rst_x5", dut.regfile_unit.registers[5], 64'h0);
    check("rst_mm", {63'h0, npu_start_matrix_mul}, 64'h0);
    rst = 1'b0;
    exp_pc = 64'h0;

    dut.regfile_unit.registers[6] = 64'd25;
    dut.regfile_unit.registers[7] = 64'd17;
    instr = 64'h00730533;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("add_alu", alu_result, 64'd42);
      check("add_pc", pc, exp_pc);
      tick();
      exp_pc += 4;
    end
    check("add_x10", dut.regfile_unit.registers[10], 64'd42);

    dut.regfile_unit.registers[6] = 64'd5;
    instr = 64'h40730533;
    #1 check("sub_alu", alu_result, 64'hFFFF_FFFF_FFFF_FFF4);
    tick(); exp_pc += 4;
    check("sub_x10", dut.regfile_unit.registers[10],
          64'hFFFF_FFFF_FFFF_FFF4);

    instr = 64'h00700013;
    #1 check("addi_x0_alu", alu_result, 64'd7);
    tick(); exp_pc += 4;
    check("addi_x0", dut.regfile_unit.registers[0], 64'h0);
    instr = 64'hFFF00093;
    tick(); exp_pc += 4;
    check("addi_x1", dut.regfile_unit.registers[1], '1);

    dut.regfile_unit.registers[2] = 64'h100;
    dut.regfile_unit.registers[3] = 64'hABCD;
    instr = 64'h00313423;
    #1;
    check("sd_we", {63'h0, mem_write_enable}, 64'h1);
    check("sd_addr", mem_addr, 64'h108);
    check("sd_data", write_data, 64'hABCD);
    tick(); exp_pc += 4;

    read_data = 64'h55;
    instr = 64'h00013203;
    #1;
    check("ld_addr", mem_addr, 64'h100);
    check("ld_we", {63'h0, mem_write_enable}, 64'h0);
    tick(); exp_pc += 4;
    check("ld_x4", dut.regfile_unit.registers[4], 64'h55);
    check("ld_pc", pc, exp_pc);

    // SRAI x13, x10, 2 : -12 >>> 2 = -3
    instr = {32'h0, 6'b010000, 6'd2, 5'd10, 3'b101, 5'd13, 7'b0010011};
    tick(); exp_pc += 4;
    check("srai_x13", dut.regfile_unit.registers[13],
          64'hFFFF_FFFF_FFFF_FFFD);

    // SLT x14, x10, x6 : -12 < 5 signed ; SLTU x15, x10, x6 : not below
    instr = {32'h0, 7'd0, 5'd6, 5'd10, 3'b010, 5'd14, 7'b0110011};
    tick(); exp_pc += 4;
    check("slt_x14", dut.regfile_unit.registers[14], 64'h1);
    instr = {32'h0, 7'd0, 5'd6, 5'd10, 3'b011, 5'd15, 7'b0110011};
    tick(); exp_pc += 4;
    check("sltu_x15", dut.regfile_unit.registers[15], 64'h0);

    // SLL x16, x6, x7 : shift by 17
    instr = {32'h0, 7'd0, 5'd7, 5'd6, 3'b001, 5'd16, 7'b0110011};
    tick(); exp_pc += 4;
    check("sll_x16", dut.regfile_unit.registers[16], 64'd5 << 17);

    instr = b_type(13'd16, 5'd6, 5'd6, 3'b000);
    tick(); exp_pc += 16;
    check("beq_taken", pc, exp_pc);
    instr = b_type(13'd16, 5'd6, 5'd6, 3'b001);
    tick(); exp_pc += 4;
    check("bne_not", pc, exp_pc);

    instr = j_type(-21'sd8, 5'd11);
    tick();
    check("jal_x11", dut.regfile_unit.registers[11], exp_pc + 4);
    exp_pc -= 8;
    check("jal_pc", pc, exp_pc);

    instr = {32'h0, 20'h80000, 5'd12, 7'b0110111};
    tick(); exp_pc += 4;
    check("lui_x12", dut.regfile_unit.registers[12],
          64'hFFFF_FFFF_8000_0000);

    instr = 64'hFFFF_FFFF;
    #1 check("unk_we", {63'h0, mem_write_enable}, 64'h0);
    tick(); exp_pc += 4;
    check("unk_pc", pc, exp_pc);
    check("unk_x31", dut.regfile_unit.registers[31], 64'h0);

    npu_done = 1'b1;
    instr = 64'h13;
    tick(); exp_pc += 4;
    check("done_idle_pc", pc, exp_pc);
    npu_done = 1'b0;

    instr = 64'h0000000B;
`ifdef CPU_NPU_EN
    #1;
    check("npu_mm_pulse", {63'h0, npu_start_matrix_mul}, 64'h1);
    check("npu_conv_off", {63'h0, npu_start_conv}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("npu_mm_low", {63'h0, npu_start_matrix_mul}, 64'h0);
      check("npu_pc_hold", pc, exp_pc);
    end
    npu_done = 1'b1;
    tick(); exp_pc += 4;
    npu_done = 1'b0;
    check("npu_pc_adv", pc, exp_pc);
`else
    #1;
    check("npu_mm_off", {63'h0, npu_start_matrix_mul}, 64'h0);
    check("npu_conv_off", {63'h0, npu_start_conv}, 64'h0);
    tick(); exp_pc += 4;
    check("npu_nop_pc", pc, exp_pc);
`endif

    rst = 1'b1;
    tick();
    check("rst2_pc", pc, 64'h0);
    check("rst2_x10", dut.regfile_unit.registers[10], 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end
endmodule
